llc_in_arbiter: RTL and testbench

- Input stage directly upstream of the LLC core.
- Buffers the three incoming LLC channels (coherence responses, CPU coherence requests, DMA requests) in small per-channel FIFOs.
- Arbitrates among them and presents a single registered message, tagged with its source channel, to the LLC core.
- Enforces response priority (deadlock avoidance), req/DMA round-robin fairness, and DMA-write-burst atomicity against CPU requests.

---
 rtl/llc_in_arbiter.sv | 276 +++++++++++++++++++++++++++
 tb/tb_llc_in_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_in_arbiter.sv
// LLC input stage: per-channel FIFOs for rsp/req/dma feeding one registered output.
// Responses always win; req/dma share by round-robin; a DMA write burst locks out req.
module llc_in_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_ready,
  output logic         o_nempty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  // Ready comes only from the registered count, so a full FIFO stays not-ready while popping.
  assign o_ready  = (r_cnt != FULL);
  assign o_nempty = (r_cnt != '0);
  assign o_data   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      if (i_push && !i_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (i_pop && !i_push) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end
endmodule

module llc_in_arbiter #(
  parameter int FIFO_DEPTH  = 2,
  parameter int DMA_LOCK_EN = 1,
  parameter int COH_MSG_W   = 2,
  parameter int MIX_MSG_W   = 3,
  parameter int HPROT_W     = 2,
  parameter int ADDR_W      = 26,
  parameter int LINE_W      = 64,
  parameter int CACHE_ID_W  = 4,
  parameter int DEV_ID_W    = 6,
  parameter int WORD_OFF_W  = 2,
  parameter logic [MIX_MSG_W-1:0] REQ_DMA_WRITE = MIX_MSG_W'(6)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rsp_in_valid,
  output logic                  rsp_in_ready,
  input  logic [COH_MSG_W-1:0]  rsp_in_coh_msg,
  input  logic [ADDR_W-1:0]     rsp_in_addr,
  input  logic [LINE_W-1:0]     rsp_in_line,
  input  logic [CACHE_ID_W-1:0] rsp_in_req_id,
  input  logic                  req_in_valid,
  output logic                  req_in_ready,
  input  logic [MIX_MSG_W-1:0]  req_in_coh_msg,
  input  logic [HPROT_W-1:0]    req_in_hprot,
  input  logic [ADDR_W-1:0]     req_in_addr,
  input  logic [LINE_W-1:0]     req_in_line,
  input  logic [CACHE_ID_W-1:0] req_in_req_id,
  input  logic [WORD_OFF_W-1:0] req_in_word_offset,
  input  logic [WORD_OFF_W-1:0] req_in_valid_words,
  input  logic                  dma_req_in_valid,
  output logic                  dma_req_in_ready,
  input  logic [MIX_MSG_W-1:0]  dma_req_in_coh_msg,
  input  logic [HPROT_W-1:0]    dma_req_in_hprot,
  input  logic [ADDR_W-1:0]     dma_req_in_addr,
  input  logic [LINE_W-1:0]     dma_req_in_line,
  input  logic [DEV_ID_W-1:0]   dma_req_in_req_id,
  input  logic [WORD_OFF_W-1:0] dma_req_in_word_offset,
  input  logic [WORD_OFF_W-1:0] dma_req_in_valid_words,
  output logic                  llc_in_valid,
  input  logic                  llc_in_ready,
  output logic [1:0]            llc_in_chan,
  output logic [MIX_MSG_W-1:0]  llc_in_coh_msg,
  output logic [HPROT_W-1:0]    llc_in_hprot,
  output logic [ADDR_W-1:0]     llc_in_addr,
  output logic [LINE_W-1:0]     llc_in_line,
  output logic [DEV_ID_W-1:0]   llc_in_req_id,
  output logic [WORD_OFF_W-1:0] llc_in_word_offset,
  output logic [WORD_OFF_W-1:0] llc_in_valid_words,
  output logic                  dma_lock
);
  localparam int RSP_W = COH_MSG_W + ADDR_W + LINE_W + CACHE_ID_W;
  localparam int REQ_W = MIX_MSG_W + HPROT_W + ADDR_W + LINE_W + CACHE_ID_W + 2*WORD_OFF_W;
  localparam int DMA_W = MIX_MSG_W + HPROT_W + ADDR_W + LINE_W + DEV_ID_W + 2*WORD_OFF_W;

  typedef enum logic {RR_REQ = 1'b0, RR_DMA = 1'b1} rr_e;

  logic [RSP_W-1:0] w_rsp_head;
  logic [REQ_W-1:0] w_req_head;
  logic [DMA_W-1:0] w_dma_head;
  logic w_rsp_ne, w_req_ne, w_dma_ne;
  logic w_req_elig, w_gnt_rsp, w_gnt_req, w_gnt_dma, w_load;

  logic [COH_MSG_W-1:0]  w_rsp_msg;
  logic [ADDR_W-1:0]     w_rsp_addr;
  logic [LINE_W-1:0]     w_rsp_line;
  logic [CACHE_ID_W-1:0] w_rsp_id;
  logic [MIX_MSG_W-1:0]  w_req_msg;
  logic [HPROT_W-1:0]    w_req_hprot;
  logic [ADDR_W-1:0]     w_req_addr;
  logic [LINE_W-1:0]     w_req_line;
  logic [CACHE_ID_W-1:0] w_req_id;
  logic [WORD_OFF_W-1:0] w_req_wo, w_req_vw;
  logic [MIX_MSG_W-1:0]  w_dma_msg;
  logic [HPROT_W-1:0]    w_dma_hprot;
  logic [ADDR_W-1:0]     w_dma_addr;
  logic [LINE_W-1:0]     w_dma_line;
  logic [DEV_ID_W-1:0]   w_dma_id;
  logic [WORD_OFF_W-1:0] w_dma_wo, w_dma_vw;

  logic [1:0]            w_nxt_chan;
  logic [MIX_MSG_W-1:0]  w_nxt_msg;
  logic [HPROT_W-1:0]    w_nxt_hprot;
  logic [ADDR_W-1:0]     w_nxt_addr;
  logic [LINE_W-1:0]     w_nxt_line;
  logic [DEV_ID_W-1:0]   w_nxt_id;
  logic [WORD_OFF_W-1:0] w_nxt_wo, w_nxt_vw;

  logic                  r_valid;
  logic [1:0]            r_chan;
  logic [MIX_MSG_W-1:0]  r_msg;
  logic [HPROT_W-1:0]    r_hprot;
  logic [ADDR_W-1:0]     r_addr;
  logic [LINE_W-1:0]     r_line;
  logic [DEV_ID_W-1:0]   r_id;
  logic [WORD_OFF_W-1:0] r_wo, r_vw;
  logic                  r_dma_lock;
  rr_e                   r_rr;

  llc_in_fifo #(.W(RSP_W), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk(clk), .rst(rst),
    .i_push(rsp_in_valid && rsp_in_ready),
    .i_data({rsp_in_coh_msg, rsp_in_addr, rsp_in_line, rsp_in_req_id}),
    .i_pop(w_load && w_gnt_rsp),
    .o_data(w_rsp_head), .o_ready(rsp_in_ready), .o_nempty(w_rsp_ne)
  );

  llc_in_fifo #(.W(REQ_W), .DEPTH(FIFO_DEPTH)) u_req_fifo (
    .clk(clk), .rst(rst),
    .i_push(req_in_valid && req_in_ready),
    .i_data({req_in_coh_msg, req_in_hprot, req_in_addr, req_in_line, req_in_req_id,
             req_in_word_offset, req_in_valid_words}),
    .i_pop(w_load && w_gnt_req),
    .o_data(w_req_head), .o_ready(req_in_ready), .o_nempty(w_req_ne)
  );

  llc_in_fifo #(.W(DMA_W), .DEPTH(FIFO_DEPTH)) u_dma_fifo (
    .clk(clk), .rst(rst),
    .i_push(dma_req_in_valid && dma_req_in_ready),
    .i_data({dma_req_in_coh_msg, dma_req_in_hprot, dma_req_in_addr, dma_req_in_line,
             dma_req_in_req_id, dma_req_in_word_offset, dma_req_in_valid_words}),
    .i_pop(w_load && w_gnt_dma),
    .o_data(w_dma_head), .o_ready(dma_req_in_ready), .o_nempty(w_dma_ne)
  );

  assign {w_rsp_msg, w_rsp_addr, w_rsp_line, w_rsp_id} = w_rsp_head;
  assign {w_req_msg, w_req_hprot, w_req_addr, w_req_line, w_req_id, w_req_wo, w_req_vw} = w_req_head;
  assign {w_dma_msg, w_dma_hprot, w_dma_addr, w_dma_line, w_dma_id, w_dma_wo, w_dma_vw} = w_dma_head;

  // While a DMA write burst owns the core, CPU requests must not slip in between beats.
  assign w_req_elig = w_req_ne && !((DMA_LOCK_EN != 0) && r_dma_lock);

  always_comb begin
    w_gnt_rsp = 1'b0;
    w_gnt_req = 1'b0;
    w_gnt_dma = 1'b0;
    if (w_rsp_ne)                    w_gnt_rsp = 1'b1;
    else if (w_req_elig && w_dma_ne) begin
      if (r_rr == RR_DMA) w_gnt_dma = 1'b1;
      else                w_gnt_req = 1'b1;
    end
    else if (w_req_elig)             w_gnt_req = 1'b1;
    else if (w_dma_ne)               w_gnt_dma = 1'b1;
  end

  assign w_load = (!r_valid || llc_in_ready) && (w_gnt_rsp || w_gnt_req || w_gnt_dma);

  always_comb begin
    w_nxt_chan  = 2'd0;
    w_nxt_msg   = '0;
    w_nxt_hprot = '0;
    w_nxt_addr  = '0;
    w_nxt_line  = '0;
    w_nxt_id    = '0;
    w_nxt_wo    = '0;
    w_nxt_vw    = '0;
    if (w_gnt_rsp) begin
      w_nxt_msg  = MIX_MSG_W'(w_rsp_msg);
      w_nxt_addr = w_rsp_addr;
      w_nxt_line = w_rsp_line;
      w_nxt_id   = DEV_ID_W'(w_rsp_id);
    end else if (w_gnt_req) begin
      w_nxt_chan  = 2'd1;
      w_nxt_msg   = w_req_msg;
      w_nxt_hprot = w_req_hprot;
      w_nxt_addr  = w_req_addr;
      w_nxt_line  = w_req_line;
      w_nxt_id    = DEV_ID_W'(w_req_id);
      w_nxt_wo    = w_req_wo;
      w_nxt_vw    = w_req_vw;
    end else if (w_gnt_dma) begin
      w_nxt_chan  = 2'd2;
      w_nxt_msg   = w_dma_msg;
      w_nxt_hprot = w_dma_hprot;
      w_nxt_addr  = w_dma_addr;
      w_nxt_line  = w_dma_line;
      w_nxt_id    = w_dma_id;
      w_nxt_wo    = w_dma_wo;
      w_nxt_vw    = w_dma_vw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid    <= 1'b0;
      r_chan     <= '0;
      r_msg      <= '0;
      r_hprot    <= '0;
      r_addr     <= '0;
      r_line     <= '0;
      r_id       <= '0;
      r_wo       <= '0;
      r_vw       <= '0;
      r_dma_lock <= 1'b0;
      r_rr       <= RR_REQ;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_chan  <= w_nxt_chan;
        r_msg   <= w_nxt_msg;
        r_hprot <= w_nxt_hprot;
        r_addr  <= w_nxt_addr;
        r_line  <= w_nxt_line;
        r_id    <= w_nxt_id;
        r_wo    <= w_nxt_wo;
        r_vw    <= w_nxt_vw;
      end else if (llc_in_ready) begin
        r_valid <= 1'b0;
      end
      if (w_load && w_gnt_req) r_rr <= RR_DMA;
      // hprot[0] marks "more beats follow"; the last beat releases the lock.
      if (w_load && w_gnt_dma) begin
        r_rr <= RR_REQ;
        if (!w_dma_hprot[0])                  r_dma_lock <= 1'b0;
        else if (w_dma_msg == REQ_DMA_WRITE) r_dma_lock <= 1'b1;
      end
    end
  end

  assign llc_in_valid       = r_valid;
  assign llc_in_chan        = r_chan;
  assign llc_in_coh_msg     = r_msg;
  assign llc_in_hprot       = r_hprot;
  assign llc_in_addr        = r_addr;
  assign llc_in_line        = r_line;
  assign llc_in_req_id      = r_id;
  assign llc_in_word_offset = r_wo;
  assign llc_in_valid_words = r_vw;
  assign dma_lock           = r_dma_lock;
endmodule

// File: tb/tb_llc_in_arbiter.sv
// Bench for llc_in_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_llc_in_arbiter;
  localparam int DEPTH   = 2;
  localparam int LOCK_EN = 1;
  localparam logic [2:0] DMA_WR = 3'd6;
  localparam logic [2:0] DMA_RD = 3'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rsp_in_valid = 1'b0, rsp_in_ready;
  logic [1:0]  rsp_in_coh_msg = '0;
  logic [25:0] rsp_in_addr = '0;
  logic [63:0] rsp_in_line = '0;
  logic [3:0]  rsp_in_req_id = '0;
  logic        req_in_valid = 1'b0, req_in_ready;
  logic [2:0]  req_in_coh_msg = '0;
  logic [1:0]  req_in_hprot = '0;
  logic [25:0] req_in_addr = '0;
  logic [63:0] req_in_line = '0;
  logic [3:0]  req_in_req_id = '0;
  logic [1:0]  req_in_word_offset = '0, req_in_valid_words = '0;
  logic        dma_req_in_valid = 1'b0, dma_req_in_ready;
  logic [2:0]  dma_req_in_coh_msg = '0;
  logic [1:0]  dma_req_in_hprot = '0;
  logic [25:0] dma_req_in_addr = '0;
  logic [63:0] dma_req_in_line = '0;
  logic [5:0]  dma_req_in_req_id = '0;
  logic [1:0]  dma_req_in_word_offset = '0, dma_req_in_valid_words = '0;
  logic        llc_in_valid, llc_in_ready = 1'b1;
  logic [1:0]  llc_in_chan;
  logic [2:0]  llc_in_coh_msg;
  logic [1:0]  llc_in_hprot;
  logic [25:0] llc_in_addr;
  logic [63:0] llc_in_line;
  logic [5:0]  llc_in_req_id;
  logic [1:0]  llc_in_word_offset, llc_in_valid_words;
  logic        dma_lock;

  llc_in_arbiter #(.FIFO_DEPTH(DEPTH), .DMA_LOCK_EN(LOCK_EN)) dut (
    .clk(clk), .rst(rst),
    .rsp_in_valid(rsp_in_valid), .rsp_in_ready(rsp_in_ready), .rsp_in_coh_msg(rsp_in_coh_msg),
    .rsp_in_addr(rsp_in_addr), .rsp_in_line(rsp_in_line), .rsp_in_req_id(rsp_in_req_id),
    .req_in_valid(req_in_valid), .req_in_ready(req_in_ready), .req_in_coh_msg(req_in_coh_msg),
    .req_in_hprot(req_in_hprot), .req_in_addr(req_in_addr), .req_in_line(req_in_line),
    .req_in_req_id(req_in_req_id), .req_in_word_offset(req_in_word_offset),
    .req_in_valid_words(req_in_valid_words),
    .dma_req_in_valid(dma_req_in_valid), .dma_req_in_ready(dma_req_in_ready),
    .dma_req_in_coh_msg(dma_req_in_coh_msg), .dma_req_in_hprot(dma_req_in_hprot),
    .dma_req_in_addr(dma_req_in_addr), .dma_req_in_line(dma_req_in_line),
    .dma_req_in_req_id(dma_req_in_req_id), .dma_req_in_word_offset(dma_req_in_word_offset),
    .dma_req_in_valid_words(dma_req_in_valid_words),
    .llc_in_valid(llc_in_valid), .llc_in_ready(llc_in_ready), .llc_in_chan(llc_in_chan),
    .llc_in_coh_msg(llc_in_coh_msg), .llc_in_hprot(llc_in_hprot), .llc_in_addr(llc_in_addr),
    .llc_in_line(llc_in_line), .llc_in_req_id(llc_in_req_id),
    .llc_in_word_offset(llc_in_word_offset), .llc_in_valid_words(llc_in_valid_words),
    .dma_lock(dma_lock)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Message layout: {chan, msg, hprot, addr, line, id, word_offset, valid_words}
  function automatic logic [106:0] pk(logic [1:0] ch, logic [2:0] m, logic [1:0] hp,
                                      logic [25:0] a, logic [63:0] l, logic [5:0] id,
                                      logic [1:0] wo, logic [1:0] vw);
    return {ch, m, hp, a, l, id, wo, vw};
  endfunction

  logic [106:0] q_rsp[$], q_req[$], q_dma[$];
  logic         m_valid, m_lock, m_turn_dma;
  logic [106:0] m_out;

  task automatic model_step();
    bit a_rsp, a_req, a_dma, req_ok;
    logic [106:0] e;
    a_rsp  = rsp_in_valid && (q_rsp.size() < DEPTH);
    a_req  = req_in_valid && (q_req.size() < DEPTH);
    a_dma  = dma_req_in_valid && (q_dma.size() < DEPTH);
    req_ok = (q_req.size() != 0) && !(LOCK_EN != 0 && m_lock);
    if (!m_valid || llc_in_ready) begin
      if (q_rsp.size() != 0) begin
        m_out = q_rsp.pop_front(); m_valid = 1'b1;
      end else if (req_ok && (q_dma.size() == 0 || !m_turn_dma)) begin
        m_out = q_req.pop_front(); m_valid = 1'b1; m_turn_dma = 1'b1;
      end else if (q_dma.size() != 0) begin
        e = q_dma.pop_front(); m_out = e; m_valid = 1'b1; m_turn_dma = 1'b0;
        if (e[100] == 1'b0) m_lock = 1'b0;
        else if (e[104:102] == DMA_WR) m_lock = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (a_rsp) q_rsp.push_back(pk(2'd0, {1'b0, rsp_in_coh_msg}, 2'b00, rsp_in_addr, rsp_in_line,
                                  {2'b00, rsp_in_req_id}, 2'b00, 2'b00));
    if (a_req) q_req.push_back(pk(2'd1, req_in_coh_msg, req_in_hprot, req_in_addr, req_in_line,
                                  {2'b00, req_in_req_id}, req_in_word_offset, req_in_valid_words));
    if (a_dma) q_dma.push_back(pk(2'd2, dma_req_in_coh_msg, dma_req_in_hprot, dma_req_in_addr,
                                  dma_req_in_line, dma_req_in_req_id, dma_req_in_word_offset,
                                  dma_req_in_valid_words));
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_rsp.delete(); q_req.delete(); q_dma.delete();
      m_valid = 1'b0; m_lock = 1'b0; m_turn_dma = 1'b0; m_out = '0;
    end else begin
      model_step();
    end
  end

  task automatic tick();
    @(negedge clk);
    chk("rsp_ready", rsp_in_ready, q_rsp.size() < DEPTH);
    chk("req_ready", req_in_ready, q_req.size() < DEPTH);
    chk("dma_ready", dma_req_in_ready, q_dma.size() < DEPTH);
    chk("out_valid", llc_in_valid, m_valid);
    chk("dma_lock", dma_lock, m_lock);
    if (m_valid)
      chk("payload", pk(llc_in_chan, llc_in_coh_msg, llc_in_hprot, llc_in_addr, llc_in_line,
                        llc_in_req_id, llc_in_word_offset, llc_in_valid_words), m_out);
  endtask

  task automatic drv_rsp(input bit v);
    rsp_in_valid = v; rsp_in_coh_msg = 2'($urandom); rsp_in_addr = 26'($urandom);
    rsp_in_line = {$urandom, $urandom}; rsp_in_req_id = 4'($urandom);
  endtask

  task automatic drv_req(input bit v, input logic [25:0] a);
    req_in_valid = v; req_in_coh_msg = 3'($urandom); req_in_hprot = 2'($urandom);
    req_in_addr = a; req_in_line = {$urandom, $urandom}; req_in_req_id = 4'($urandom);
    req_in_word_offset = 2'($urandom); req_in_valid_words = 2'($urandom);
  endtask

  task automatic drv_dma(input bit v, input logic [2:0] m, input bit more);
    dma_req_in_valid = v; dma_req_in_coh_msg = m; dma_req_in_hprot = {1'($urandom), more};
    dma_req_in_addr = 26'($urandom); dma_req_in_line = {$urandom, $urandom};
    dma_req_in_req_id = 6'($urandom); dma_req_in_word_offset = 2'($urandom);
    dma_req_in_valid_words = 2'($urandom);
  endtask

  task automatic idle();
    rsp_in_valid = 1'b0; req_in_valid = 1'b0; dma_req_in_valid = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_valid", llc_in_valid, 1'b0);
    chk("rst_lock", dma_lock, 1'b0);
    chk("rst_rsp_ready", rsp_in_ready, 1'b1);
    chk("rst_req_ready", req_in_ready, 1'b1);
    chk("rst_dma_ready", dma_req_in_ready, 1'b1);
    chk("rst_payload", pk(llc_in_chan, llc_in_coh_msg, llc_in_hprot, llc_in_addr, llc_in_line,
                          llc_in_req_id, llc_in_word_offset, llc_in_valid_words), '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk_reset_state();
    tick();

    // Single req: output valid two edges after acceptance
    drv_req(1'b1, 26'h40);
    tick();
    idle();
    cyc = 1;
    while (!llc_in_valid && cyc < 10) begin tick(); cyc++; end
    chk("latency", cyc, 2);
    chk("lat_chan", llc_in_chan, 2'd1);
    chk("lat_addr", llc_in_addr, 26'h40);
    repeat (3) tick();

    // Two req + two dma backlogged, then released
    llc_in_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv_req(1'b1, 26'h100 + 26'(i)); drv_dma(1'b1, DMA_RD, 1'b0); tick();
    end
    idle(); tick();
    llc_in_ready = 1'b1;
    repeat (8) tick();

    // Response arriving behind a req/dma backlog
    llc_in_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv_req(1'b1, 26'h200 + 26'(i)); drv_dma(1'b1, DMA_RD, 1'b0); tick();
    end
    idle(); drv_rsp(1'b1); tick();
    idle(); tick();
    llc_in_ready = 1'b1;
    repeat (8) tick();

    // Three-beat DMA write burst interleaved with two reqs
    drv_dma(1'b1, DMA_WR, 1'b1); drv_req(1'b1, 26'h300); tick();
    drv_dma(1'b1, DMA_WR, 1'b1); drv_req(1'b1, 26'h301); tick();
    idle(); drv_dma(1'b1, DMA_WR, 1'b0); tick();
    idle();
    repeat (10) tick();

    // Backpressure: five stalled cycles with req pushing every cycle
    llc_in_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin drv_req(1'b1, 26'h400 + 26'(i)); tick(); end
    idle(); llc_in_ready = 1'b1;
    repeat (8) tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 35) drv_rsp(1'b1); else rsp_in_valid = 1'b0;
      if ($urandom_range(99) < 50) drv_req(1'b1, 26'($urandom)); else req_in_valid = 1'b0;
      if ($urandom_range(99) < 50)
        drv_dma(1'b1, $urandom_range(1) ? DMA_WR : DMA_RD, 1'($urandom));
      else dma_req_in_valid = 1'b0;
      llc_in_ready = ($urandom_range(99) < 70);
      tick();
    end
    idle(); llc_in_ready = 1'b1;
    repeat (12) tick();

    // Reset in the middle of a locked burst
    drv_dma(1'b1, DMA_WR, 1'b1); tick();
    idle();
    cyc = 0;
    while (!dma_lock && cyc < 10) begin tick(); cyc++; end
    chk("lock_set", dma_lock, 1'b1);
    llc_in_ready = 1'b0;
    drv_req(1'b1, 26'h500); drv_rsp(1'b1); drv_dma(1'b1, DMA_WR, 1'b1); tick();
    idle();
    #2 rst = 1'b0;
    #1 chk_reset_state();
    tick();
    chk_reset_state();
    rst = 1'b1; llc_in_ready = 1'b1;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
